// File: rtl/pedal_pkg.sv
// Shared types and constants for the effect-chain scheduler.
package pedal_pkg;
  localparam int NUM_FX          = 4;
  localparam int SAMPLE_W        = 24;
  localparam int OPT_W           = 4;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // Isolates the lowest set bit, which is the next effect to run.
  function automatic logic [NUM_FX-1:0] lowest_set(input logic [NUM_FX-1:0] m);
    return m & (~m + {{(NUM_FX-1){1'b0}}, 1'b1});
  endfunction
endpackage

// File: rtl/fx_timeout_counter.sv
// Per-effect watchdog: loaded when an effect is started, counts down while
// the scheduler waits, and flags expiry on the last allowed wait cycle.
module fx_timeout_counter
  import pedal_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Loading TIMEOUT-1 makes expiry fall on exactly the TIMEOUT-th wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(TIMEOUT - 1);
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = i_count && (r_cnt == '0);
endmodule

// File: rtl/effect_chain_sched.sv
// Sequences one audio sample through the enabled effects in index order,
// with a per-effect timeout bypass and sticky overrun/fault reporting.
module effect_chain_sched
  import pedal_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  sample_t                    sample_in,
  input  logic                       sample_valid,
  input  logic [NUM_FX-1:0]          en,
  input  logic [OPT_W-1:0]           options0,
  input  logic [OPT_W-1:0]           options1,
  input  logic [OPT_W-1:0]           options2,
  input  logic [OPT_W-1:0]           options3,
  output logic [NUM_FX-1:0]          fx_start,
  output sample_t                    fx_data,
  output logic [OPT_W-1:0]           fx_opt,
  input  logic [NUM_FX-1:0]          fx_done,
  input  logic [NUM_FX*SAMPLE_W-1:0] fx_result,
  output sample_t                    sample_out,
  output logic                       sample_out_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic [NUM_FX-1:0]          fault,
  input  logic                       clr_flags
);
  state_t                  r_state, w_state_nxt;
  sample_t                 r_acc, w_acc_nxt, w_res;
  logic [NUM_FX-1:0]       r_pend, w_pend_nxt;
  logic [NUM_FX-1:0]       r_cur, w_cur_nxt;
  logic [NUM_FX*OPT_W-1:0] r_opt_snap, w_opt_snap_nxt;
  logic [OPT_W-1:0]        w_opt_sel;
  logic [NUM_FX-1:0]       w_fault_set;
  logic                    w_load_cnt, w_count, w_expired, w_hit;
  logic                    w_emit, w_overrun_set;

  logic [NUM_FX-1:0]       r_fx_start;
  sample_t                 r_fx_data;
  logic [OPT_W-1:0]        r_fx_opt;
  sample_t                 r_sample_out;
  logic                    r_sample_out_valid;
  logic                    r_overrun;
  logic [NUM_FX-1:0]       r_fault;

  fx_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load_cnt),
    .i_count   (w_count),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_pend_nxt     = r_pend;
    w_cur_nxt      = r_cur;
    w_opt_snap_nxt = r_opt_snap;
    w_fault_set    = '0;
    w_load_cnt     = 1'b0;
    w_count        = 1'b0;
    w_hit          = 1'b0;
    w_emit         = 1'b0;
    w_overrun_set  = sample_valid && (r_state != IDLE);

    w_res = '0;
    for (int k = 0; k < NUM_FX; k++) begin
      if (r_cur[k]) w_res = fx_result[k*SAMPLE_W +: SAMPLE_W];
    end

    case (r_state)
      IDLE: begin
        if (sample_valid) begin
          w_acc_nxt      = sample_in;
          w_pend_nxt     = en;
          w_opt_snap_nxt = {options3, options2, options1, options0};
          w_cur_nxt      = lowest_set(en);
          w_state_nxt    = (en != '0) ? ISSUE : EMIT;
        end
      end
      ISSUE: begin
        w_load_cnt  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_count = 1'b1;
        w_hit   = |(fx_done & r_cur);
        // A done arriving on the expiry cycle still counts as a result.
        if (w_hit || w_expired) begin
          if (w_hit) w_acc_nxt = w_res;
          else       w_fault_set = r_cur;
          w_pend_nxt  = r_pend & ~r_cur;
          w_cur_nxt   = lowest_set(w_pend_nxt);
          w_state_nxt = (w_pend_nxt != '0) ? ISSUE : EMIT;
        end
      end
      EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_opt_sel = '0;
    for (int k = 0; k < NUM_FX; k++) begin
      if (w_cur_nxt[k]) w_opt_sel = w_opt_snap_nxt[k*OPT_W +: OPT_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= IDLE;
      r_acc              <= '0;
      r_pend             <= '0;
      r_cur              <= '0;
      r_opt_snap         <= '0;
      r_fx_start         <= '0;
      r_fx_data          <= '0;
      r_fx_opt           <= '0;
      r_sample_out       <= '0;
      r_sample_out_valid <= 1'b0;
      r_overrun          <= 1'b0;
      r_fault            <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_pend     <= w_pend_nxt;
      r_cur      <= w_cur_nxt;
      r_opt_snap <= w_opt_snap_nxt;
      // Operands are captured on entry to ISSUE and held until the next issue.
      r_fx_start <= (w_state_nxt == ISSUE) ? w_cur_nxt : '0;
      if (w_state_nxt == ISSUE) begin
        r_fx_data <= w_acc_nxt;
        r_fx_opt  <= w_opt_sel;
      end
      r_sample_out_valid <= w_emit;
      if (w_emit) r_sample_out <= r_acc;
      r_overrun <= (r_overrun & ~clr_flags) | w_overrun_set;
      r_fault   <= (r_fault & {NUM_FX{~clr_flags}}) | w_fault_set;
    end
  end

  assign fx_start         = r_fx_start;
  assign fx_data          = r_fx_data;
  assign fx_opt           = r_fx_opt;
  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_sample_out_valid;
  assign busy             = (r_state != IDLE);
  assign overrun          = r_overrun;
  assign fault            = r_fault;
endmodule

// File: tb/tb_effect_chain_sched.sv
// Directed bench for effect_chain_sched with behavioural effect responders.
module tb_effect_chain_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [3:0]  en = '0;
  logic [3:0]  options0 = '0, options1 = '0, options2 = '0, options3 = '0;
  logic [3:0]  fx_start;
  logic [23:0] fx_data;
  logic [3:0]  fx_opt;
  logic [3:0]  fx_done = '0;
  logic [95:0] fx_result = '0;
  logic [23:0] sample_out;
  logic        sample_out_valid, busy, overrun;
  logic [3:0]  fault;
  logic        clr_flags = 1'b0;

  effect_chain_sched #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .en(en), .options0(options0), .options1(options1), .options2(options2),
    .options3(options3), .fx_start(fx_start), .fx_data(fx_data), .fx_opt(fx_opt),
    .fx_done(fx_done), .fx_result(fx_result), .sample_out(sample_out),
    .sample_out_valid(sample_out_valid), .busy(busy), .overrun(overrun),
    .fault(fault), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int n_out = 0;
  int last_lat = 0;
  int stab_err = 0;
  logic [23:0] last_out = '0;
  logic [15:0] start_log = '0;

  // Effect model: mode 0 returns x+1, mode 1 returns x*2, mode 2 never answers.
  int          fx_lat[4];
  int          fx_mode[4];
  int          rem[4];
  logic [3:0]  rbusy = '0;
  logic [23:0] cap_data[4];
  logic [3:0]  cap_opt[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_out_valid) begin
      n_out    = n_out + 1;
      last_out = sample_out;
      last_lat = cyc - t0;
    end
    if (fx_start != 4'b0) start_log = {start_log[11:0], fx_start};
    fx_done = '0;
    if (rst) rbusy = '0;
    for (int k = 0; k < 4; k++) begin
      if (rbusy[k]) begin
        if (fx_data !== cap_data[k] || fx_opt !== cap_opt[k]) stab_err = stab_err + 1;
        rem[k] = rem[k] - 1;
        if (rem[k] == 0 && fx_mode[k] != 2) begin
          fx_done[k] = 1'b1;
          fx_result[k*24 +: 24] = (fx_mode[k] == 0) ? cap_data[k] + 24'd1 : cap_data[k] * 24'd2;
          rbusy[k] = 1'b0;
        end
      end
      if (fx_start[k] && !rst) begin
        rbusy[k]    = 1'b1;
        rem[k]      = fx_lat[k];
        cap_data[k] = fx_data;
        cap_opt[k]  = fx_opt;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] x);
    sample_in    = x;
    sample_valid = 1'b1;
    t0           = cyc;
    step(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget);
    int n = 0;
    while (n_out < target && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_out", 32'(n_out >= target), 32'd1);
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      fx_lat[k] = 2; fx_mode[k] = 0; rem[k] = 0; cap_data[k] = '0; cap_opt[k] = '0;
    end
    step(2);
    chk("rst_fx_start", 32'(fx_start), 32'h0);
    chk("rst_fx_data", 32'(fx_data), 32'h0);
    chk("rst_fx_opt", 32'(fx_opt), 32'h0);
    chk("rst_sample_out", 32'(sample_out), 32'h0);
    chk("rst_valid", 32'(sample_out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    rst = 1'b0;
    step(1);

    // Bypass chain: no effects enabled.
    en = 4'b0000;
    send(24'h012345);
    wait_out(1, 10);
    chk("bypass_out", 32'(last_out), 32'h012345);
    chk("bypass_lat", 32'(last_lat), 32'd2);
    step(3);
    chk("bypass_hold", 32'(sample_out), 32'h012345);
    chk("bypass_idle", 32'(busy), 32'h0);

    // Effects 0 and 2: (10+1)*2 = 22.
    en = 4'b0101;
    options0 = 4'd3; options1 = 4'd5; options2 = 4'd9; options3 = 4'd7;
    fx_mode[0] = 0; fx_lat[0] = 3;
    fx_mode[2] = 1; fx_lat[2] = 5;
    start_log = '0;
    stab_err  = 0;
    send(24'd10);
    wait_out(2, 40);
    chk("chain_out", 32'(last_out), 32'd22);
    chk("chain_starts", 32'(start_log), 32'h0014);
    chk("chain_lat", 32'(last_lat), 32'd12);
    chk("chain_data2", 32'(cap_data[2]), 32'd11);
    chk("chain_opt0", 32'(cap_opt[0]), 32'd3);
    chk("chain_opt2", 32'(cap_opt[2]), 32'd9);
    chk("chain_stable", 32'(stab_err), 32'd0);

    // Effect 1 never answers: bypassed after 8 wait cycles.
    en = 4'b0010;
    fx_mode[1] = 2;
    send(24'h000123);
    wait_out(3, 40);
    chk("tmo_fault", 32'(fault), 32'h2);
    chk("tmo_out", 32'(last_out), 32'h000123);
    chk("tmo_lat", 32'(last_lat), 32'd11);
    chk("tmo_overrun", 32'(overrun), 32'h0);

    // Second sample during WAIT is dropped.
    en = 4'b0001;
    fx_mode[0] = 0; fx_lat[0] = 6;
    send(24'd100);
    step(3);
    sample_in = 24'd200; sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    wait_out(4, 40);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_out", 32'(last_out), 32'd101);
    chk("ovr_lat", 32'(last_lat), 32'd9);
    step(5);
    chk("ovr_count", 32'(n_out), 32'd4);
    clear_flags();
    chk("clr_overrun", 32'(overrun), 32'h0);
    chk("clr_fault", 32'(fault), 32'h0);

    // Overrun set and clr_flags in the same cycle: set wins.
    send(24'd5);
    step(1);
    sample_in = 24'd77; sample_valid = 1'b1; clr_flags = 1'b1;
    step(1);
    sample_valid = 1'b0; clr_flags = 1'b0;
    chk("set_wins", 32'(overrun), 32'h1);
    wait_out(5, 40);
    chk("set_wins_out", 32'(last_out), 32'd6);
    clear_flags();

    // Sample arriving during EMIT is an overrun.
    en = 4'b0000;
    send(24'd7);
    sample_in = 24'd8; sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    wait_out(6, 10);
    chk("emit_ovr_out", 32'(last_out), 32'd7);
    chk("emit_ovr_flag", 32'(overrun), 32'h1);
    step(4);
    chk("emit_ovr_count", 32'(n_out), 32'd6);
    clear_flags();

    // Reset during WAIT of effect 3.
    en = 4'b1000;
    fx_mode[3] = 0; fx_lat[3] = 20;
    send(24'h55);
    step(5);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_fx_start", 32'(fx_start), 32'h0);
    chk("mid_rst_fx_data", 32'(fx_data), 32'h0);
    chk("mid_rst_fx_opt", 32'(fx_opt), 32'h0);
    chk("mid_rst_out", 32'(sample_out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step(25);
    chk("mid_rst_no_out", 32'(n_out), 32'd6);
    en = 4'b0000;
    send(24'h0ABCDE);
    wait_out(7, 10);
    chk("post_rst_out", 32'(last_out), 32'h0ABCDE);
    chk("post_rst_lat", 32'(last_lat), 32'd2);

    // Enables dropped mid-chain: snapshot still runs all four.
    en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      fx_mode[k] = 0; fx_lat[k] = 2;
    end
    start_log = '0;
    send(24'd1000);
    en = 4'b0000;
    wait_out(8, 60);
    chk("snap_starts", 32'(start_log), 32'h1248);
    chk("snap_out", 32'(last_out), 32'd1004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
